// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period tick generator: one-cycle tick every CLKS_PER_BIT clocks while
// enabled, counter held at zero while disabled.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_l,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!en)                cnt_d = '0;
    else if (cnt_q == LAST) cnt_d = '0;
    else                    cnt_d = cnt_q + 1'b1;
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, LSB-first data, optional even parity
// (enabled by defining UART_TX_PARITY_EN) and stop bits onto tx.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bitCnt_q, bitCnt_d;
  logic                 tick;
  logic                 handshake;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign handshake = tx_valid && (state_q == IDLE);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst_l (rst_l),
    .en    (busy),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // The bit counter is reused to count stop bits once the data bits are out.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d  = START;
          shift_d  = tx_data;
          bitCnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bitCnt_q == LAST_DATA) begin
            bitCnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
`else
            state_d  = STOP;
`endif
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (bitCnt_q == LAST_STOP) begin
            bitCnt_d = '0;
            state_d  = IDLE;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx       = LINE_IDLE;
    tx_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
      end
      START: tx = ~LINE_IDLE;
      DATA:  tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = parity_q;
`endif
      STOP:  done = tick && (bitCnt_q == LAST_STOP);
      default: tx = LINE_IDLE;
    endcase
  end

endmodule
